// File: rtl/status_array_arbiter.sv
// status_array_arbiter
//
// Owns the single port of the status (valid-bit) array and shares it between
// three requesters: the status array initializer, the refill/invalidate write
// path and the lookup read path. Until the initializer reports completion only
// init beats reach the array. After that, writes win over reads.
//
// Configuration macro:
//   STATUS_ARB_STARVE_GUARD_EN - when defined, a saturating starve counter
//     forces a pending read through once it has lost STARVE_LIMIT consecutive
//     RUN cycles. When undefined, writes have strict priority and no counter
//     exists.
//
// Ports:
//   clk, arst_n              clock, asynchronous active-low reset
//   i_halt                   freeze: all readies 0, all registers hold
//   i_init_*                 initializer command (addr/data/wen/wmask/valid)
//   i_init_complete          initializer finished, enter RUN
//   o_init_ready             init beat accepted
//   i_wr_*                   refill/invalidate write (addr/data/wmask/valid)
//   o_wr_ready               write accepted
//   i_rd_addr, i_rd_valid    lookup read request
//   o_rd_ready               read accepted
//   o_addr/o_data/o_wen/o_wmask/o_valid   registered array command
//   i_arr_rdata              array read data, one cycle after a read command
//   o_rd_data                i_arr_rdata passed through
//   o_rd_data_valid          registered, high when o_rd_data is valid
//
// The parameter defaults mirror the shared project parameters.
module status_array_arbiter #(
  parameter int ADDR_WIDTH   = 4,
  parameter int ROW_WIDTH    = 8,
  parameter int NUM_BLOCKS   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_halt,
  input  logic [ADDR_WIDTH-1:0] i_init_addr,
  input  logic [ROW_WIDTH-1:0]  i_init_data,
  input  logic                  i_init_wen,
  input  logic [NUM_BLOCKS-1:0] i_init_wmask,
  input  logic                  i_init_valid,
  input  logic                  i_init_complete,
  output logic                  o_init_ready,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [ROW_WIDTH-1:0]  i_wr_data,
  input  logic [NUM_BLOCKS-1:0] i_wr_wmask,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_rd_valid,
  output logic                  o_rd_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [ROW_WIDTH-1:0]  o_data,
  output logic                  o_wen,
  output logic [NUM_BLOCKS-1:0] o_wmask,
  output logic                  o_valid,
  input  logic [ROW_WIDTH-1:0]  i_arr_rdata,
  output logic [ROW_WIDTH-1:0]  o_rd_data,
  output logic                  o_rd_data_valid
);

  // One-hot style encoding so that corrupted encodings are detectable.
  typedef enum logic [1:0] {
    ST_INIT = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ROW_WIDTH-1:0]    data_q, data_d;
  logic                    wen_q, wen_d;
  logic [NUM_BLOCKS-1:0]   wmask_q, wmask_d;
  logic                    valid_q, valid_d;
  logic                    rd_data_valid_q, rd_data_valid_d;

  logic grant_wr, grant_rd;
  logic in_run;
  logic init_xfer, wr_xfer, rd_xfer;

  assign in_run = (state_q == ST_RUN);

`ifdef STATUS_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             force_rd;

  // A read that has lost STARVE_LIMIT cycles in a row beats the writer once.
  assign force_rd = i_rd_valid && (starve_q == CNT_W'(STARVE_LIMIT));
  assign grant_wr = i_wr_valid && !force_rd;
  assign grant_rd = i_rd_valid && (!i_wr_valid || force_rd);

  always_comb begin
    starve_d = starve_q;
    if (in_run && !i_halt) begin
      if (rd_xfer) begin
        starve_d = '0;
      end else if (i_rd_valid && (starve_q != CNT_W'(STARVE_LIMIT))) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign grant_wr = i_wr_valid;
  assign grant_rd = i_rd_valid && !i_wr_valid;
`endif

  assign o_init_ready = (state_q == ST_INIT) && !i_halt;
  assign o_wr_ready   = in_run && grant_wr && !i_halt;
  assign o_rd_ready   = in_run && grant_rd && !i_halt;

  assign init_xfer = o_init_ready && i_init_valid;
  assign wr_xfer   = o_wr_ready;
  assign rd_xfer   = o_rd_ready;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    data_d          = data_q;
    wen_d           = wen_q;
    wmask_d         = wmask_q;
    valid_d         = valid_q;
    rd_data_valid_d = rd_data_valid_q;

    // While halted everything holds; the array is frozen too, so a read
    // command left on the port is sampled only after release.
    if (!i_halt) begin
      // The array answers one cycle after it samples a read command.
      rd_data_valid_d = valid_q && !wen_q;
      valid_d         = 1'b0;
      wen_d           = 1'b0;

      case (state_q)
        ST_INIT: begin
          if (init_xfer) begin
            addr_d  = i_init_addr;
            data_d  = i_init_data;
            wen_d   = i_init_wen;
            wmask_d = i_init_wmask;
            valid_d = 1'b1;
          end
          if (i_init_complete) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (wr_xfer) begin
            addr_d  = i_wr_addr;
            data_d  = i_wr_data;
            wen_d   = 1'b1;
            wmask_d = i_wr_wmask;
            valid_d = 1'b1;
          end else if (rd_xfer) begin
            addr_d  = i_rd_addr;
            data_d  = '0;
            wmask_d = '0;
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end

    // A corrupted state recovers even while halted.
    if ((state_q != ST_INIT) && (state_q != ST_RUN)) begin
      state_d = ST_INIT;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q         <= ST_INIT;
      addr_q          <= '0;
      data_q          <= '0;
      wen_q           <= 1'b0;
      wmask_q         <= '0;
      valid_q         <= 1'b0;
      rd_data_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      wen_q           <= wen_d;
      wmask_q         <= wmask_d;
      valid_q         <= valid_d;
      rd_data_valid_q <= rd_data_valid_d;
    end
  end

  assign o_addr          = addr_q;
  assign o_data          = data_q;
  assign o_wen           = wen_q;
  assign o_wmask         = wmask_q;
  assign o_valid         = valid_q;
  assign o_rd_data       = i_arr_rdata;
  assign o_rd_data_valid = rd_data_valid_q;

endmodule

// File: tb/tb_status_array_arbiter.sv
// Testbench for status_array_arbiter: directed vectors with hand-computed
// expectations, plus a small behavioural model of the status array that sits
// on the command port and returns read data one cycle later.
module tb_status_array_arbiter;

  localparam int AW = 4;
  localparam int RW = 8;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          i_halt;
  logic [AW-1:0] i_init_addr;
  logic [RW-1:0] i_init_data;
  logic          i_init_wen;
  logic [NB-1:0] i_init_wmask;
  logic          i_init_valid;
  logic          i_init_complete;
  logic          o_init_ready;
  logic [AW-1:0] i_wr_addr;
  logic [RW-1:0] i_wr_data;
  logic [NB-1:0] i_wr_wmask;
  logic          i_wr_valid;
  logic          o_wr_ready;
  logic [AW-1:0] i_rd_addr;
  logic          i_rd_valid;
  logic          o_rd_ready;
  logic [AW-1:0] o_addr;
  logic [RW-1:0] o_data;
  logic          o_wen;
  logic [NB-1:0] o_wmask;
  logic          o_valid;
  logic [RW-1:0] i_arr_rdata;
  logic [RW-1:0] o_rd_data;
  logic          o_rd_data_valid;

  int checks = 0;
  int errors = 0;

  status_array_arbiter #(
    .ADDR_WIDTH  (AW),
    .ROW_WIDTH   (RW),
    .NUM_BLOCKS  (NB),
    .STARVE_LIMIT(4)
  ) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .i_halt         (i_halt),
    .i_init_addr    (i_init_addr),
    .i_init_data    (i_init_data),
    .i_init_wen     (i_init_wen),
    .i_init_wmask   (i_init_wmask),
    .i_init_valid   (i_init_valid),
    .i_init_complete(i_init_complete),
    .o_init_ready   (o_init_ready),
    .i_wr_addr      (i_wr_addr),
    .i_wr_data      (i_wr_data),
    .i_wr_wmask     (i_wr_wmask),
    .i_wr_valid     (i_wr_valid),
    .o_wr_ready     (o_wr_ready),
    .i_rd_addr      (i_rd_addr),
    .i_rd_valid     (i_rd_valid),
    .o_rd_ready     (o_rd_ready),
    .o_addr         (o_addr),
    .o_data         (o_data),
    .o_wen          (o_wen),
    .o_wmask        (o_wmask),
    .o_valid        (o_valid),
    .i_arr_rdata    (i_arr_rdata),
    .o_rd_data      (o_rd_data),
    .o_rd_data_valid(o_rd_data_valid)
  );

  always #5 clk = ~clk;

  // Status array model: shares i_halt, masked writes, registered reads.
  logic [RW-1:0] mem [0:(1<<AW)-1];
  int            writes_9 = 0;

  always @(posedge clk) begin
    if (!i_halt && o_valid) begin
      if (o_wen) begin
        mem[o_addr] <= (mem[o_addr] & ~o_wmask) | (o_data & o_wmask);
        if (o_addr == 4'd9) writes_9 <= writes_9 + 1;
      end else begin
        i_arr_rdata <= mem[o_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int first_grant;
  int rd_grants;
  int base_9;

  initial begin
    arst_n = 1'b0; i_halt = 1'b0;
    i_init_addr = '0; i_init_data = '0; i_init_wen = 1'b0; i_init_wmask = '0;
    i_init_valid = 1'b0; i_init_complete = 1'b0;
    i_wr_addr = '0; i_wr_data = '0; i_wr_wmask = '0; i_wr_valid = 1'b0;
    i_rd_addr = '0; i_rd_valid = 1'b0;
    i_arr_rdata = '0;

    // Reset state.
    step(); step();
    check("rst_o_valid", 32'(o_valid), 0);
    check("rst_o_wen", 32'(o_wen), 0);
    check("rst_o_addr", 32'(o_addr), 0);
    check("rst_o_data", 32'(o_data), 0);
    check("rst_o_wmask", 32'(o_wmask), 0);
    check("rst_rd_data_valid", 32'(o_rd_data_valid), 0);
    check("rst_init_ready", 32'(o_init_ready), 1);
    arst_n = 1'b1;

    // Initialization: every address written once, rd/wr held off.
    i_wr_valid = 1'b1; i_wr_addr = 4'd1; i_wr_data = 8'hFF; i_wr_wmask = 8'hFF;
    i_rd_valid = 1'b1; i_rd_addr = 4'd2;
    for (int a = 0; a < 16; a++) begin
      i_init_addr  = 4'(a);
      i_init_data  = 8'(a) ^ 8'hA5;
      i_init_wen   = 1'b1;
      i_init_wmask = 8'hFF;
      i_init_valid = 1'b1;
      #1;
      check($sformatf("init%0d_init_ready", a), 32'(o_init_ready), 1);
      check($sformatf("init%0d_wr_rd_ready", a), {o_wr_ready, o_rd_ready}, 0);
      step();
      check($sformatf("init%0d_cmd", a), {o_valid, o_wen, o_wmask, o_data, 4'(o_addr)},
            {1'b1, 1'b1, 8'hFF, 8'(a) ^ 8'hA5, 4'(a)});
    end
    i_init_valid = 1'b0; i_wr_valid = 1'b0; i_rd_valid = 1'b0;
    i_init_complete = 1'b1;
    #1;
    check("init_last_wr_ready", 32'(o_wr_ready), 0);
    step();
    i_init_complete = 1'b0;
    check("run_init_ready", 32'(o_init_ready), 0);
    check("run_idle_valid", 32'(o_valid), 0);

    // Lone read of address 5: port in N+1, data in N+2 (5 ^ A5 = A0).
    i_rd_valid = 1'b1; i_rd_addr = 4'd5;
    #1;
    check("rd5_ready", {o_rd_ready, o_wr_ready}, 2'b10);
    step();
    i_rd_valid = 1'b0;
    check("rd5_cmd", {o_valid, o_wen, o_wmask, o_data, 4'(o_addr)}, {2'b10, 8'h00, 8'h00, 4'd5});
    check("rd5_n1_rdv", 32'(o_rd_data_valid), 0);
    step();
    check("rd5_rdv", 32'(o_rd_data_valid), 1);
    check("rd5_data", 32'(o_rd_data), 32'hA0);
    check("rd5_n2_valid", 32'(o_valid), 0);
    step();
    check("rd5_rdv_drop", 32'(o_rd_data_valid), 0);

    // Same-address write and read: write first, read observes 0x0A.
    i_wr_valid = 1'b1; i_wr_addr = 4'd3; i_wr_data = 8'h0A; i_wr_wmask = 8'hFF;
    i_rd_valid = 1'b1; i_rd_addr = 4'd3;
    #1;
    check("wr3_rd3_ready", {o_wr_ready, o_rd_ready}, 2'b10);
    step();
    i_wr_valid = 1'b0;
    check("wr3_cmd", {o_valid, o_wen, o_data, 4'(o_addr)}, {2'b11, 8'h0A, 4'd3});
    #1;
    check("rd3_ready", 32'(o_rd_ready), 1);
    step();
    i_rd_valid = 1'b0;
    check("rd3_cmd", {o_valid, o_wen, 4'(o_addr)}, {2'b10, 4'd3});
    step();
    check("rd3_data", {o_rd_data_valid, o_rd_data}, {1'b1, 8'h0A});

    // Continuous writes with a pending read.
    i_wr_valid = 1'b1; i_wr_addr = 4'd7; i_wr_data = 8'h11; i_wr_wmask = 8'hFF;
    i_rd_valid = 1'b1; i_rd_addr = 4'd2;
    first_grant = 0; rd_grants = 0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (o_rd_ready) begin
        rd_grants++;
        if (first_grant == 0) first_grant = k;
      end
      step();
      if (first_grant != 0) i_rd_valid = 1'b0;
    end
`ifdef STATUS_ARB_STARVE_GUARD_EN
    check("starve_first_grant", 32'(first_grant), 5);
`else
    check("starve_rd_grants", 32'(rd_grants), 0);
`endif
    i_wr_valid = 1'b0; i_rd_valid = 1'b0;
    step(); step();

    // Halt for 3 cycles with a read response pending and a write waiting.
    base_9 = writes_9;
    i_rd_valid = 1'b1; i_rd_addr = 4'd5;
    step();
    i_rd_valid = 1'b0;
    i_halt = 1'b1;
    i_wr_valid = 1'b1; i_wr_addr = 4'd9; i_wr_data = 8'h33; i_wr_wmask = 8'hFF;
    for (int h = 0; h < 3; h++) begin
      #1;
      check($sformatf("halt%0d_readies", h), {o_init_ready, o_wr_ready, o_rd_ready}, 0);
      step();
      check($sformatf("halt%0d_cmd", h), {o_valid, o_wen, 4'(o_addr), o_rd_data_valid},
            {2'b10, 4'd5, 1'b0});
    end
    i_halt = 1'b0;
    #1;
    check("release_wr_ready", 32'(o_wr_ready), 1);
    step();
    i_wr_valid = 1'b0;
    check("release_cmd", {o_valid, o_wen, o_data, 4'(o_addr)}, {2'b11, 8'h33, 4'd9});
    check("release_rd_resp", {o_rd_data_valid, o_rd_data}, {1'b1, 8'hA0});
    step();
    check("release_idle", {o_valid, o_rd_data_valid}, 0);
    check("release_writes_9", 32'(writes_9 - base_9), 1);

    i_rd_valid = 1'b1; i_rd_addr = 4'd9;
    step();
    i_rd_valid = 1'b0;
    step();
    check("rd9_data", {o_rd_data_valid, o_rd_data}, {1'b1, 8'h33});

    // Reset in the middle of a read.
    i_rd_valid = 1'b1; i_rd_addr = 4'd12;
    step();
    check("rd12_on_port", {o_valid, 4'(o_addr)}, {1'b1, 4'd12});
    arst_n = 1'b0;
    #1;
    check("midrst_valid", {o_valid, o_rd_data_valid}, 0);
    step();
    check("midrst_rdv_held", 32'(o_rd_data_valid), 0);
    arst_n = 1'b1;
    #1;
    check("post_rst_rd_ready", 32'(o_rd_ready), 0);
    check("post_rst_init_ready", 32'(o_init_ready), 1);
    step();
    check("post_rst_no_cmd", {o_valid, o_rd_data_valid}, 0);
    i_rd_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
